// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: instruction fetch front-end with a single outstanding
// memory request and a DEPTH-entry FIFO of {pc, instruction} toward decode.
// Optional feature macro: IFB_BYPASS_EN -- when defined, a response arriving
// into an empty FIFO is presented to decode in the same cycle.
module instr_fetch_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    output logic        pc_ready,

    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,

    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,

    input  logic        flush
);

    localparam int unsigned XW = 32;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    typedef struct packed {
        logic [XW-1:0] pc;
        logic [XW-1:0] instr;
    } entry_t;

    state_t        state;
    logic [XW-1:0] pc_lat;
    logic          mem_req_q;

    entry_t        fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;

    logic          fifo_empty;
    logic          fifo_full;
    logic          pc_xfer;
    logic          beat_ok;
    logic          bypass_vis;
    logic          fifo_wr;
    logic          fifo_rd;
    entry_t        head;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CW'(DEPTH));

    // New fetch accepted only when idle, not flushing, and a slot is guaranteed
    assign pc_ready = (state == IDLE) && !flush && !fifo_full;
    assign pc_xfer  = pc_valid && pc_ready;

    // A response beat that survives (not in the flush cycle, only while waiting)
    assign beat_ok  = (state == WAIT) && mem_rvalid && !flush;

`ifdef IFB_BYPASS_EN
    assign bypass_vis = beat_ok && fifo_empty;
`else
    assign bypass_vis = 1'b0;
`endif

    // A bypassed beat that decode takes immediately never enters the FIFO
    assign fifo_wr = beat_ok && !(bypass_vis && instr_ready);
    assign fifo_rd = !fifo_empty && instr_ready;

    assign head     = fifo_mem[rd_ptr];
    assign mem_req  = mem_req_q;
    assign mem_addr = pc_lat;

    // Decode-side view: FIFO head when non-empty, else the bypassed beat, else zero
    always_comb begin
        instr_valid = 1'b0;
        instr_out   = '0;
        instr_pc    = '0;
        if (!fifo_empty) begin
            instr_valid = 1'b1;
            instr_out   = head.instr;
            instr_pc    = head.pc;
        end else if (bypass_vis) begin
            instr_valid = 1'b1;
            instr_out   = mem_rdata;
            instr_pc    = pc_lat;
        end
    end

    // Fetch control FSM: one request in flight, DROP swallows a flushed response
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            pc_lat    <= '0;
            mem_req_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pc_xfer) begin
                        pc_lat    <= pc_in;
                        mem_req_q <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (flush) begin
                        mem_req_q <= 1'b0;
                        state     <= mem_gnt ? DROP : IDLE;
                    end else if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                    end else if (flush) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; flush empties the buffer outright
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the entry is not counted
    always_ff @(posedge clk) begin
        if (reset && fifo_wr) begin
            fifo_mem[wr_ptr] <= '{pc: pc_lat, instr: mem_rdata};
        end
    end

endmodule
